// File: rtl/seq_function_unit.sv
// Function unit: single-cycle arithmetic/logic ops plus bit-serial shifts,
// with valid/ready handshakes on both the request and result sides.
module seq_function_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FunctionSelect,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Negative,
  output logic             Zero,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [1:0]       sh_op;
  logic             accept, is_shift;
  logic [SHW-1:0]   k;

  logic [WIDTH-1:0] op2;
  logic             cin, arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign is_shift  = (FunctionSelect[3:2] == 2'b11) && (FunctionSelect[1:0] != 2'b00);
  assign k         = B[SHW-1:0];

  // Opcodes 0001-0110 share one adder; the second operand and carry-in select the op.
  always_comb begin
    op2   = '0;
    cin   = 1'b0;
    arith = 1'b0;
    case (FunctionSelect)
      4'b0001: begin cin = 1'b1; arith = 1'b1; end
      4'b0010: begin op2 = B; arith = 1'b1; end
      4'b0011: begin op2 = B; cin = 1'b1; arith = 1'b1; end
      4'b0100: begin op2 = ~B; arith = 1'b1; end
      4'b0101: begin op2 = ~B; cin = 1'b1; arith = 1'b1; end
      4'b0110: begin op2 = '1; arith = 1'b1; end
      default: ;
    endcase
    sum     = {1'b0, A} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    alu_res = A;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (arith) begin
      alu_res = sum[WIDTH-1:0];
      alu_c   = sum[WIDTH];
      alu_v   = (A[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end else begin
      case (FunctionSelect)
        4'b1000: alu_res = A & B;
        4'b1001: alu_res = A | B;
        4'b1010: alu_res = A ^ B;
        4'b1011: alu_res = ~A;
        4'b1100: alu_res = B;
        default: alu_res = A;
      endcase
    end
  end

  // One-bit shift step applied to the value held in Result while in SHIFT.
  always_comb begin
    case (sh_op)
      2'b01: begin
        sh_next = {Result[WIDTH-2:0], 1'b0};
        sh_out  = Result[WIDTH-1];
      end
      2'b10: begin
        sh_next = {1'b0, Result[WIDTH-1:1]};
        sh_out  = Result[0];
      end
      default: begin
        sh_next = {Result[WIDTH-1], Result[WIDTH-1:1]};
        sh_out  = Result[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sh_op    <= 2'b00;
      Result   <= '0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Negative <= 1'b0;
      Zero     <= 1'b0;
    end else if (accept) begin
      if (is_shift) begin
        Result   <= A;
        Overflow <= 1'b0;
        CarryOut <= 1'b0;
        Negative <= A[WIDTH-1];
        Zero     <= (A == '0);
        sh_op    <= FunctionSelect[1:0];
        cnt      <= k;
        state    <= (k == '0) ? DONE : SHIFT;
      end else begin
        Result   <= alu_res;
        Overflow <= alu_v;
        CarryOut <= alu_c;
        Negative <= alu_res[WIDTH-1];
        Zero     <= (alu_res == '0);
        state    <= DONE;
      end
    end else begin
      case (state)
        SHIFT: begin
          Result   <= sh_next;
          CarryOut <= sh_out;
          Negative <= sh_next[WIDTH-1];
          Zero     <= (sh_next == '0);
          cnt      <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= DONE;
        end
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_function_unit.sv
// Randomized and directed checks of seq_function_unit against a behavioural model.
module tb_seq_function_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0, B = '0;
  logic [3:0]  FunctionSelect = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Result;
  logic        Overflow, CarryOut, Negative, Zero, busy;

  int total = 0;
  int bad = 0;

  seq_function_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FunctionSelect(FunctionSelect),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Overflow(Overflow), .CarryOut(CarryOut), .Negative(Negative),
    .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: result, flags {V,C,N,Z} and edges from accept to out_valid.
  task automatic model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [3:0] fl, output int lat);
    int ua, ub, nb, s, sa, sr, kk;
    logic v, c;
    ua = int'(a); ub = int'(b); nb = 65535 - ub;
    sa = a[15] ? ua - 65536 : ua;
    v = 1'b0; c = 1'b0; lat = 1; s = ua;
    sr = 0;
    case (fs)
      4'd1:  begin s = ua + 1;       sr = sa + 1; end
      4'd2:  begin s = ua + ub;      sr = sa + (b[15] ? ub - 65536 : ub); end
      4'd3:  begin s = ua + ub + 1;  sr = sa + (b[15] ? ub - 65536 : ub) + 1; end
      4'd4:  begin s = ua + nb;      sr = sa - (b[15] ? ub - 65536 : ub) - 1; end
      4'd5:  begin s = ua + nb + 1;  sr = sa - (b[15] ? ub - 65536 : ub); end
      4'd6:  begin s = ua + 65535;   sr = sa - 1; end
      4'd8:  s = ua & ub;
      4'd9:  s = ua | ub;
      4'd10: s = ua ^ ub;
      4'd11: s = 65535 - ua;
      4'd12: s = ub;
      default: s = ua;
    endcase
    if (fs >= 4'd1 && fs <= 4'd6) begin
      c = (s >= 65536);
      v = (sr > 32767) || (sr < -32768);
    end
    kk = ub % 16;
    if (fs >= 4'd13) begin
      lat = (kk == 0) ? 1 : kk + 1;
      if (fs == 4'd13) begin
        s = (ua << kk) % 65536;
        c = (kk == 0) ? 1'b0 : 1'((ua >> (16 - kk)) % 2);
      end else begin
        s = (fs == 4'd14) ? (ua >> kk) : ((sa >>> kk) & 65535);
        c = (kk == 0) ? 1'b0 : 1'((ua >> (kk - 1)) % 2);
      end
    end
    r  = 16'(s);
    fl = {v, c, r[15], r == 16'h0};
  endtask

  // Issue one op (consuming any held result at the same edge), wait for the
  // result, check it, then hold it under backpressure for 0..2 cycles.
  task automatic do_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic [3:0]  ef;
    int lat, n;
    logic b0;
    model(fs, a, b, er, ef, lat);
    @(negedge clk);
    FunctionSelect = fs; A = a; B = b;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    A = 16'($urandom); B = 16'($urandom); FunctionSelect = 4'($urandom);
    b0 = busy;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_first", 32'(b0), 32'(lat > 1));
    chk("latency", 32'(n), 32'(lat));
    chk("result", 32'(Result), 32'(er));
    chk("flags_vcnz", 32'({Overflow, CarryOut, Negative, Zero}), 32'(ef));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      chk("hold_result", 32'({out_valid, in_ready, Result, Overflow, CarryOut, Negative, Zero}),
          32'({1'b1, 1'b0, er, ef}));
    end
  endtask

  initial begin
    int stray;
    #2;
    chk("reset_outputs", 32'({out_valid, busy, in_ready, Result, Overflow, CarryOut, Negative, Zero}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed corner cases
    do_op(4'b0010, 16'h7FFF, 16'h0001);
    do_op(4'b0101, 16'h0005, 16'h0005);
    do_op(4'b0110, 16'h0000, 16'h0000);
    do_op(4'b1101, 16'h8001, 16'h0001);
    do_op(4'b1111, 16'h8000, 16'h0004);
    do_op(4'b1110, 16'h1234, 16'h0000);
    do_op(4'b1100, 16'h0000, 16'h1234);

    for (int i = 0; i < 150; i++)
      do_op(4'($urandom), 16'($urandom), 16'($urandom));

    // Back-to-back single-cycle ops with no backpressure
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    FunctionSelect = 4'b0001; A = 16'h0001; B = 16'h0000;
    #1 chk("b2b_ready0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_res0", 32'({out_valid, Result}), 32'({1'b1, 16'h0002}));
    FunctionSelect = 4'b1000; A = 16'hF0F0; B = 16'h0FF0;
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_res1", 32'({out_valid, Result}), 32'({1'b1, 16'h00F0}));
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    FunctionSelect = 4'b1110; A = 16'hFFFF; B = 16'h000F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("busy_mid_shift", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("async_reset", 32'({out_valid, busy, in_ready, Result, Overflow, CarryOut, Negative, Zero}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst2", 32'(in_ready), 32'd1);
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || busy) stray++;
    end
    chk("no_stray_valid", 32'(stray), 32'd0);
    do_op(4'b0000, 16'hABCD, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
